// File: rtl/mem_responder_pkg.sv
// Shared types and widths for the external-bus memory responder.
package mem_responder_pkg;

   localparam int RESP_DATA_W = 8;
   localparam int RESP_ADDR_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } resp_state_t;

endpackage

// File: rtl/mem_responder_tristate.sv
// Plain tristate buffer: drives y with a while en is high, Z otherwise.
module tristate #(
   parameter int W = 8
) (
   input  logic         en,
   input  logic [W-1:0] a,
   output wire  [W-1:0] y
);

   assign y = en ? a : {W{1'bz}};

endmodule

// File: rtl/mem_responder.sv
// Bus target answering CPU read/write cycles inside an address window,
// with programmable wait states and a one-cycle ready acknowledge.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter logic [15:0] BASE        = 16'h0000,
   parameter int          MEM_WORDS   = 256,
   parameter int          WAIT_STATES = 1
) (
   input  logic                   clk,
   input  logic                   resetb,
   input  logic                   req,
   input  logic                   rw,
   input  logic [RESP_ADDR_W-1:0] address,
   inout  wire  [RESP_DATA_W-1:0] data,
   output logic                   ready,
   output logic                   busy
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam logic [RESP_ADDR_W:0] LIMIT =
      {1'b0, BASE} + (RESP_ADDR_W+1)'(MEM_WORDS);
   localparam logic [3:0] CNT_INIT =
      (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   // Handshake: the initiator raises req with address/rw/data and holds them
   // until it samples ready high for one cycle; the responder only samples a
   // new req while IDLE, so back-to-back cycles see at least one bubble.
   resp_state_t             state, state_d;
   logic [3:0]              cnt, cnt_d;
   logic                    load;
   logic                    hit;
   logic [IDX_W-1:0]        index_q;
   logic                    rw_q;
   logic [RESP_DATA_W-1:0]  wdata_q;
   logic [RESP_DATA_W-1:0]  mem [MEM_WORDS];
   logic [RESP_DATA_W-1:0]  rd_byte;
   logic                    drive_en;

   // Compared at 17 bits so a window touching the top of memory cannot wrap.
   assign hit = (address >= BASE) && ({1'b0, address} < LIMIT);

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      load    = 1'b0;
      case (state)
         IDLE: begin
            if (req && hit) begin
               load = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_d = ACK;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (!req) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else if (cnt == 4'd0) begin
               state_d = ACK;
            end else begin
               cnt_d = cnt - 4'd1;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetb) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         index_q <= IDX_W'(address - BASE);
         rw_q    <= rw;
         wdata_q <= data;
      end
   end

   // Reset at the closing edge of ACK suppresses the commit.
   always_ff @(posedge clk) begin
      if (resetb && (state == ACK) && !rw_q) begin
         mem[index_q] <= wdata_q;
      end
   end

   assign ready    = (state == ACK);
   assign busy     = (state != IDLE);
   assign rd_byte  = mem[index_q];
   assign drive_en = (state == ACK) && rw_q;

   tristate #(.W(RESP_DATA_W)) u_data_drv (
      .en (drive_en),
      .a  (rd_byte),
      .y  (data)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: table of single transfers plus
// hand-written abort, reset and back-to-back sequences.
module tb_mem_responder;

   logic        clk;
   logic        resetb;
   logic        req;
   logic        rw;
   logic [15:0] address;
   logic [7:0]  tb_data;
   logic        tb_drive;
   wire  [7:0]  data;
   logic        ready;
   logic        busy;
   int          cyc;
   int          checks;
   int          errors;

   // Undriven bus floats high, so a released bus reads as 8'hFF.
   assign data = tb_drive ? tb_data : 8'hzz;
   for (genvar gi = 0; gi < 8; gi++) begin : g_pu
      pullup (data[gi]);
   end

   mem_responder #(
      .BASE        (16'h0200),
      .MEM_WORDS   (256),
      .WAIT_STATES (2)
   ) dut (
      .clk     (clk),
      .resetb  (resetb),
      .req     (req),
      .rw      (rw),
      .address (address),
      .data    (data),
      .ready   (ready),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        r;
      logic [15:0] a;
      logic [7:0]  wd;
      int          exp_rdy;
      logic [7:0]  exp_rd;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Cycle 0 presents the request; cycle c is sampled 3 time units after its edge.
   task automatic xfer(input logic r, input logic [15:0] a, input logic [7:0] wd,
                       input int max_cyc, input int drop_at, input int busy_n,
                       output int rdy_cyc, output int rdy_abs, output logic [7:0] rd,
                       output int n_rdy, output bit busy_ok, output bit z_ok);
      rdy_cyc = -1;
      rdy_abs = -1;
      rd      = 8'h00;
      n_rdy   = 0;
      busy_ok = 1'b1;
      z_ok    = 1'b1;
      @(posedge clk); #1;
      req      = 1'b1;
      rw       = r;
      address  = a;
      tb_data  = wd;
      tb_drive = !r;
      for (int c = 1; c <= max_cyc; c++) begin
         @(posedge clk); #1;
         if (c == drop_at) begin
            req      = 1'b0;
            tb_drive = 1'b0;
         end
         #2;
         if (busy !== (c <= busy_n)) busy_ok = 1'b0;
         if (ready === 1'b1) begin
            n_rdy++;
            rdy_cyc = c;
            rdy_abs = cyc;
            rd      = data;
            break;
         end
         if (!tb_drive && data !== 8'hFF) z_ok = 1'b0;
      end
   endtask

   task automatic idle(input int n, output bit quiet);
      quiet = 1'b1;
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         req      = 1'b0;
         tb_drive = 1'b0;
         #2;
         if (ready !== 1'b0 || busy !== 1'b0 || data !== 8'hFF) quiet = 1'b0;
      end
   endtask

   initial begin
      int          rc, ra, nr, ra1, ra2;
      logic [7:0]  rd, rd1, rd2;
      bit          bok, zok, q;

      checks   = 0;
      errors   = 0;
      resetb   = 1'b0;
      req      = 1'b0;
      rw       = 1'b1;
      address  = 16'h0000;
      tb_data  = 8'h00;
      tb_drive = 1'b0;

      vecs[0] = '{1'b0, 16'h0210, 8'hA5,  3, 8'h00};
      vecs[1] = '{1'b1, 16'h0210, 8'h00,  3, 8'hA5};
      vecs[2] = '{1'b0, 16'h02FF, 8'h5A,  3, 8'h00};
      vecs[3] = '{1'b0, 16'h0300, 8'h77, -1, 8'h00};
      vecs[4] = '{1'b1, 16'h02FF, 8'h00,  3, 8'h5A};
      vecs[5] = '{1'b0, 16'h0200, 8'hC3,  3, 8'h00};
      vecs[6] = '{1'b1, 16'h0200, 8'h00,  3, 8'hC3};
      vecs[7] = '{1'b1, 16'h01FF, 8'h00, -1, 8'h00};
      vecs[8] = '{1'b1, 16'h0100, 8'h00, -1, 8'h00};
      vecs[9] = '{1'b0, 16'h0220, 8'h11,  3, 8'h00};

      repeat (3) @(posedge clk);
      #1 resetb = 1'b1;
      #2;
      chk("reset_ready", int'(ready), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_data_z", int'(data), 8'hFF);

      for (int i = 0; i < 10; i++) begin
         xfer(vecs[i].r, vecs[i].a, vecs[i].wd, (vecs[i].exp_rdy < 0) ? 10 : 8, 0,
              (vecs[i].exp_rdy < 0) ? 0 : vecs[i].exp_rdy, rc, ra, rd, nr, bok, zok);
         chk($sformatf("vec%0d_ready_cycle", i), rc, vecs[i].exp_rdy);
         chk($sformatf("vec%0d_busy", i), int'(bok), 1);
         if (vecs[i].r) chk($sformatf("vec%0d_data_z", i), int'(zok), 1);
         if (vecs[i].r && vecs[i].exp_rdy > 0)
            chk($sformatf("vec%0d_rdata", i), int'(rd), int'(vecs[i].exp_rd));
         idle(2, q);
         chk($sformatf("vec%0d_quiet_after", i), int'(q), 1);
      end

      // Abort: drop req in the first WAIT cycle; 0x0220 keeps 0x11.
      xfer(1'b0, 16'h0220, 8'h3C, 6, 1, 1, rc, ra, rd, nr, bok, zok);
      chk("abort_no_ready", nr, 0);
      chk("abort_busy", int'(bok), 1);
      idle(2, q);
      xfer(1'b1, 16'h0220, 8'h00, 8, 0, 3, rc, ra, rd, nr, bok, zok);
      chk("abort_readback", int'(rd), 8'h11);
      chk("abort_readback_cycle", rc, 3);
      idle(2, q);

      // Reset during WAIT of a read.
      @(posedge clk); #1;
      req = 1'b1; rw = 1'b1; address = 16'h0210; tb_drive = 1'b0;
      @(posedge clk); #1;
      resetb = 1'b0;
      #2 chk("rst_wait_busy_before", int'(busy), 1);
      @(posedge clk); #1;
      resetb = 1'b1; req = 1'b0;
      #2;
      chk("rst_wait_ready", int'(ready), 0);
      chk("rst_wait_busy", int'(busy), 0);
      chk("rst_wait_data_z", int'(data), 8'hFF);
      idle(2, q);
      chk("rst_wait_quiet", int'(q), 1);
      xfer(1'b1, 16'h0210, 8'h00, 8, 0, 3, rc, ra, rd, nr, bok, zok);
      chk("rst_wait_readback", int'(rd), 8'hA5);
      idle(2, q);

      // Reset at the closing edge of a write ACK: no commit.
      @(posedge clk); #1;
      req = 1'b1; rw = 1'b0; address = 16'h0210; tb_data = 8'h99; tb_drive = 1'b1;
      repeat (3) @(posedge clk);
      #1 resetb = 1'b0;
      #2 chk("rst_ack_ready", int'(ready), 1);
      @(posedge clk); #1;
      resetb = 1'b1; req = 1'b0; tb_drive = 1'b0;
      #2 chk("rst_ack_busy", int'(busy), 0);
      idle(2, q);
      xfer(1'b1, 16'h0210, 8'h00, 8, 0, 3, rc, ra, rd, nr, bok, zok);
      chk("rst_ack_no_commit", int'(rd), 8'hA5);
      idle(2, q);

      // Back-to-back reads: next request presented right after ready.
      xfer(1'b1, 16'h0210, 8'h00, 8, 0, 3, rc, ra1, rd1, nr, bok, zok);
      xfer(1'b1, 16'h02FF, 8'h00, 8, 0, 3, rc, ra2, rd2, nr, bok, zok);
      chk("b2b_spacing", ra2 - ra1, 4);
      chk("b2b_first", int'(rd1), 8'hA5);
      chk("b2b_second", int'(rd2), 8'h5A);
      idle(2, q);
      chk("b2b_quiet", int'(q), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
